// File: rtl/sdram_refresh_arbiter.sv
// Arbitrates one SDRAM controller between two clients (round-robin, hold-until-release) and auto-refresh.
// Optional grant timeout and per-port masking are enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_refresh_arbiter #(
    parameter int REF_PERIOD    = 780,
    parameter int URGENT_THRESH = 4
`ifdef SDRAM_ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD      = 256
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    output logic       ack1,
    input  logic       req2,
    output logic       ack2,
    output logic       ref_req,
    input  logic       ref_ack,
    output logic [3:0] pending,
    output logic       ref_overrun
);

    localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [4:0] URG = 5'(URGENT_THRESH);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2, REFRESH} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          ack1_q, ack2_q, ref_req_q;
    logic          last2_q;
    logic          credit, ref_done;
    logic          mask1, mask2, expire;
    logic          eff1, eff2;
    logic          go1, go2, go_ref;

    always_comb begin
        credit    = (timer_q == '0);
        ref_done  = (state_q == REFRESH) && ref_ack;
        timer_d   = credit ? TW'(REF_PERIOD - 1) : timer_q - TW'(1);
        pending_d = pending_q;
        overrun_d = overrun_q;
        // A credit and a completed refresh in the same cycle cancel out.
        if (credit && !ref_done) begin
            if (pending_q == 4'hF)
                overrun_d = 1'b1;
            else
                pending_d = pending_q + 4'd1;
        end else if (!credit && ref_done) begin
            pending_d = pending_q - 4'd1;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_q;
    logic          mask1_q, mask2_q;

    assign expire = (hold_q == HW'(MAX_HOLD - 1));
    assign mask1  = mask1_q;
    assign mask2  = mask2_q;

    // A timed-out port stays masked until it drops its request for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            mask1_q <= 1'b0;
            mask2_q <= 1'b0;
        end else begin
            hold_q <= (state_q == GNT1 || state_q == GNT2) ? hold_q + HW'(1) : '0;
            if (!req1)
                mask1_q <= 1'b0;
            else if (state_q == GNT1 && expire)
                mask1_q <= 1'b1;
            if (!req2)
                mask2_q <= 1'b0;
            else if (state_q == GNT2 && expire)
                mask2_q <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
    assign mask1  = 1'b0;
    assign mask2  = 1'b0;
`endif

    assign eff1 = req1 && !mask1;
    assign eff2 = req2 && !mask2;

    always_comb begin
        go1    = 1'b0;
        go2    = 1'b0;
        go_ref = 1'b0;
        if ({1'b0, pending_q} >= URG) begin
            go_ref = 1'b1;
        end else if (eff1 && eff2) begin
            go1 = last2_q;
            go2 = !last2_q;
        end else if (eff1) begin
            go1 = 1'b1;
        end else if (eff2) begin
            go2 = 1'b1;
        end else if (pending_q != 4'd0) begin
            go_ref = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ack1_q    <= 1'b0;
            ack2_q    <= 1'b0;
            ref_req_q <= 1'b0;
            last2_q   <= 1'b1;
            timer_q   <= TW'(REF_PERIOD - 1);
            pending_q <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                IDLE: begin
                    if (go1) begin
                        state_q <= GNT1;
                        ack1_q  <= 1'b1;
                        last2_q <= 1'b0;
                    end else if (go2) begin
                        state_q <= GNT2;
                        ack2_q  <= 1'b1;
                        last2_q <= 1'b1;
                    end else if (go_ref) begin
                        state_q   <= REFRESH;
                        ref_req_q <= 1'b1;
                    end
                end
                GNT1: begin
                    if (!req1 || expire) begin
                        state_q <= IDLE;
                        ack1_q  <= 1'b0;
                    end
                end
                GNT2: begin
                    if (!req2 || expire) begin
                        state_q <= IDLE;
                        ack2_q  <= 1'b0;
                    end
                end
                REFRESH: begin
                    if (ref_ack) begin
                        state_q   <= IDLE;
                        ref_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ack1_q    <= 1'b0;
                    ack2_q    <= 1'b0;
                    ref_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack1        = ack1_q;
    assign ack2        = ack2_q;
    assign ref_req     = ref_req_q;
    assign pending     = pending_q;
    assign ref_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Directed bench for sdram_refresh_arbiter with a short refresh period (20 cycles).
module tb_sdram_refresh_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req1 = 1'b0, req2 = 1'b0, ref_ack = 1'b0;
    logic       ack1, ack2, ref_req, ref_overrun;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r1, r2, ra;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[15];

    sdram_refresh_arbiter #(
        .REF_PERIOD(20),
        .URGENT_THRESH(4)
`ifdef SDRAM_ARB_TIMEOUT_EN
        ,
        .MAX_HOLD(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .ack1(ack1),
        .req2(req2), .ack2(ack2),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .pending(pending), .ref_overrun(ref_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((32'(ack1) + 32'(ack2) + 32'(ref_req)) > 1) begin
            errors++;
            $display("FAIL onehot: ack1=%0b ack2=%0b ref_req=%0b, at most one may be high",
                     ack1, ack2, ref_req);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; ref_ack = 1'b0;
        step();
        step();
        chk("reset", {ack1, ack2, ref_req, ref_overrun, pending}, 8'h00);
        rst = 1'b0;
    endtask

    function automatic vec_t mkv(logic r1, logic r2, logic ra, logic [2:0] outs);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.ra = ra;
        v.exp = {outs, 4'd0};
        return v;
    endfunction

    logic bad;

    initial begin
        vecs[0]  = mkv(0, 0, 0, 3'b000);
        vecs[1]  = mkv(1, 1, 0, 3'b100);
        vecs[2]  = mkv(1, 1, 0, 3'b100);
        vecs[3]  = mkv(0, 1, 0, 3'b000);
        vecs[4]  = mkv(0, 1, 0, 3'b010);
        vecs[5]  = mkv(0, 1, 0, 3'b010);
        vecs[6]  = mkv(1, 1, 0, 3'b010);
        vecs[7]  = mkv(1, 0, 0, 3'b000);
        vecs[8]  = mkv(1, 1, 0, 3'b100);
        vecs[9]  = mkv(1, 1, 0, 3'b100);
        vecs[10] = mkv(0, 0, 0, 3'b000);
        vecs[11] = mkv(0, 0, 0, 3'b000);
        vecs[12] = mkv(1, 1, 0, 3'b010);
        vecs[13] = mkv(0, 0, 0, 3'b000);
        vecs[14] = mkv(0, 0, 1, 3'b000);

        // single grant, then first refresh credit and its ack
        do_reset();
        repeat (9) step();
        chk("t1_idle", {ack1, ack2, ref_req}, 3'b000);
        req1 = 1'b1;
        step();
        chk("t1_grant", {ack1, ack2}, 2'b10);
        repeat (6) step();
        chk("t1_hold", {ack1, ack2}, 2'b10);
        req1 = 1'b0;
        step();
        chk("t1_release", {ack1, ack2, ref_req}, 3'b000);
        repeat (3) step();
        chk("t3_credit", {ref_req, pending}, {1'b0, 4'd1});
        step();
        chk("t3_ref_req", {ack1, ack2, ref_req}, 3'b001);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        chk("t3_ref_ack", {ref_req, pending}, {1'b0, 4'd0});
        step();
        chk("t3_idle", {ack1, ack2, ref_req, pending}, 7'd0);

        // round-robin table
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req1 = vecs[i].r1; req2 = vecs[i].r2; ref_ack = vecs[i].ra;
            step();
            chk($sformatf("t2_vec%0d", i), {ack1, ack2, ref_req, pending}, vecs[i].exp);
        end
        ref_ack = 1'b0;

`ifndef SDRAM_ARB_TIMEOUT_EN
        // long grant builds a backlog; urgent refresh beats a waiting client
        do_reset();
        req1 = 1'b1;
        step();
        chk("t4_grant", {ack1, ack2, ref_req}, 3'b100);
        bad = 1'b0;
        for (int i = 2; i <= 105; i++) begin
            if (i == 50) req2 = 1'b1;
            step();
            if (ref_req || !ack1 || ack2) bad = 1'b1;
        end
        chk("t4_no_preempt", 32'(bad), 32'd0);
        chk("t4_pending5", 32'(pending), 32'd5);
        req1 = 1'b0;
        step();
        chk("t4_release", {ack1, ack2, ref_req}, 3'b000);
        step();
        chk("t4_urgent", {ack1, ack2, ref_req, pending}, {3'b001, 4'd5});
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        chk("t4_ack1", {ref_req, pending}, {1'b0, 4'd4});
        step();
        chk("t4_urgent2", {ack1, ack2, ref_req}, 3'b001);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        chk("t4_ack2", 32'(pending), 32'd3);
        step();
        chk("t4_client2", {ack1, ack2, ref_req, pending}, {3'b010, 4'd3});
        req2 = 1'b0;
`endif

        // withheld ack: saturation and overrun, with one credit+ack collision
        do_reset();
        repeat (21) step();
        chk("t5_first_ref", {ref_req, pending}, {1'b1, 4'd1});
        repeat (18) step();
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        chk("t5_simul", {ref_req, pending}, {1'b0, 4'd1});
        step();
        chk("t5_re_ref", 32'(ref_req), 32'd1);
        repeat (298) step();
        chk("t5_sat", {ref_overrun, pending}, {1'b0, 4'd15});
        step();
        chk("t5_overrun", {ref_overrun, pending}, {1'b1, 4'd15});

`ifdef SDRAM_ARB_TIMEOUT_EN
        // grant timeout and masking
        do_reset();
        req1 = 1'b1; req2 = 1'b1;
        step();
        chk("t6_grant1", {ack1, ack2}, 2'b10);
        repeat (7) step();
        chk("t6_hold8", {ack1, ack2}, 2'b10);
        step();
        chk("t6_timeout", {ack1, ack2}, 2'b00);
        step();
        chk("t6_grant2", {ack1, ack2}, 2'b01);
        req2 = 1'b0;
        step();
        chk("t6_rel2", {ack1, ack2}, 2'b00);
        step();
        chk("t6_masked_a", 32'(ack1), 32'd0);
        step();
        chk("t6_masked_b", 32'(ack1), 32'd0);
        req1 = 1'b0;
        step();
        req1 = 1'b1;
        step();
        chk("t6_regrant", {ack1, ack2}, 2'b10);
`endif

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
